fifo_read_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO. Runs entirely in the read clock domain. It synchronizes the Gray-coded write pointer from the write domain and owns the read pointer (binary and Gray). It generates the empty and almost-empty flags plus an occupancy count, and drives the read address into the dual-port FIFO memory. Accepted reads are captured into a registered data output with a one-cycle valid strobe. It is the counterpart of the write-side storage/pointer logic.

---
 rtl/fifo_read_ctrl_if.sv | 31 +++
 rtl/fifo_read_ctrl.sv | 76 +++++++
 tb/tb_fifo_read_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_read_ctrl_if : read-side port bundle of the async FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
interface fifo_read_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                r_en;
  logic [ADDRSIZE:0]   wptr;
  logic [DATASIZE-1:0] mem_rdata;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rcount;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;

  modport master (
    output r_en, wptr, mem_rdata,
    input  raddr, rptr, rempty, raempty, rcount, rdata, rvalid
  );

  modport slave (
    input  r_en, wptr, mem_rdata,
    output raddr, rptr, rempty, raempty, rcount, rdata, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_read_ctrl : read-domain pointer, flag and data-capture logic
// Rev 1.0
// ----------------------------------------------------------------------------
module fifo_read_ctrl #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AEMPTY_TH = 2
) (
  input  wire logic         rclk,
  input  wire logic         rrst,
  fifo_read_ctrl_if.slave   bus
);
  localparam logic [ADDRSIZE:0] c_aempty_th = (ADDRSIZE+1)'(AEMPTY_TH);

  logic [ADDRSIZE:0]   wq1_q, wq2_q;
  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [ADDRSIZE:0]   rptr_q, rgray_d;
  logic                rempty_q, raempty_q, rvalid_q;
  logic [ADDRSIZE:0]   rcount_q, occ_d;
  logic [DATASIZE-1:0] rdata_q;
  logic                w_rd_ok;
  logic [ADDRSIZE:0]   w_wbin;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  genvar gi;
  generate
    for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
      assign w_wbin[gi] = ^(wq2_q >> gi);
    end
  endgenerate

  always_comb begin
    w_rd_ok = bus.r_en & ~rempty_q;
    rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, w_rd_ok};
    rgray_d = (rbin_d >> 1) ^ rbin_d;
    occ_d   = w_wbin - rbin_d;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      wq1_q     <= '0;
      wq2_q     <= '0;
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rcount_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      wq1_q     <= bus.wptr;
      wq2_q     <= wq1_q;
      rbin_q    <= rbin_d;
      rptr_q    <= rgray_d;
      // Compared against the post-read pointer so the last read closes the FIFO at once
      rempty_q  <= (rgray_d == wq2_q);
      rcount_q  <= occ_d;
      raempty_q <= (occ_d <= c_aempty_th);
      rvalid_q  <= w_rd_ok;
      if (w_rd_ok) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.raddr   = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr    = rptr_q;
  assign bus.rempty  = rempty_q;
  assign bus.raempty = raempty_q;
  assign bus.rcount  = rcount_q;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_read_ctrl : vector table plus data scoreboard for fifo_read_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fifo_read_ctrl;
  typedef struct {
    int         wr;
    logic       ren;
    logic       e_empty;
    logic       e_aempty;
    logic [4:0] e_count;
    logic [3:0] e_raddr;
    logic [4:0] e_rptr;
    logic       e_rvalid;
    logic [7:0] e_rdata;
  } vec_t;

  logic rclk = 1'b0;
  logic rrst = 1'b0;
  logic [7:0] mem [16];
  logic [4:0] wbin = '0;
  logic [7:0] sb [$];
  logic [7:0] wdata [$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  vec_t vecs [17];

  fifo_read_ctrl_if #(.DATASIZE(8), .ADDRSIZE(4)) ifc ();

  fifo_read_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .AEMPTY_TH(2)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (ifc.slave)
  );

  always #5 rclk = ~rclk;

  assign ifc.mem_rdata = mem[ifc.raddr];

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    sb.push_back(d);
    wbin = wbin + 5'd1;
    ifc.wptr = gray(wbin);
  endtask

  // Scoreboard: every rvalid pulse must deliver the oldest written word
  always @(negedge rclk) begin
    if (ifc.rvalid === 1'b1) begin
      n_pulse++;
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        check("sb_rdata", {24'd0, ifc.rdata}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ifc.r_en = 1'b0;
    ifc.wptr = '0;
    wdata = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    //                 wr ren emp aem cnt  raddr rptr        rv    rdata
    vecs[0]  = '{1, 1'b0, 1'b1, 1'b1, 5'd0, 4'd0, gray(5'd0), 1'b0, 8'h00};
    vecs[1]  = '{0, 1'b0, 1'b1, 1'b1, 5'd0, 4'd0, gray(5'd0), 1'b0, 8'h00};
    vecs[2]  = '{0, 1'b1, 1'b0, 1'b1, 5'd1, 4'd0, gray(5'd0), 1'b0, 8'h00};
    vecs[3]  = '{0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd1, gray(5'd1), 1'b1, 8'hA5};
    vecs[4]  = '{0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd1, gray(5'd1), 1'b0, 8'hA5};
    vecs[5]  = '{0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd1, gray(5'd1), 1'b0, 8'hA5};
    vecs[6]  = '{0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd1, gray(5'd1), 1'b0, 8'hA5};
    vecs[7]  = '{0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd1, gray(5'd1), 1'b0, 8'hA5};
    vecs[8]  = '{0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd1, gray(5'd1), 1'b0, 8'hA5};
    vecs[9]  = '{4, 1'b0, 1'b1, 1'b1, 5'd0, 4'd1, gray(5'd1), 1'b0, 8'hA5};
    vecs[10] = '{0, 1'b0, 1'b1, 1'b1, 5'd0, 4'd1, gray(5'd1), 1'b0, 8'hA5};
    vecs[11] = '{0, 1'b0, 1'b0, 1'b0, 5'd4, 4'd1, gray(5'd1), 1'b0, 8'hA5};
    vecs[12] = '{0, 1'b1, 1'b0, 1'b0, 5'd3, 4'd2, gray(5'd2), 1'b1, 8'h11};
    vecs[13] = '{0, 1'b1, 1'b0, 1'b1, 5'd2, 4'd3, gray(5'd3), 1'b1, 8'h22};
    vecs[14] = '{0, 1'b1, 1'b0, 1'b1, 5'd1, 4'd4, gray(5'd4), 1'b1, 8'h33};
    vecs[15] = '{0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd5, gray(5'd5), 1'b1, 8'h44};
    vecs[16] = '{0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd5, gray(5'd5), 1'b0, 8'h44};

    // Power-on reset
    #2 rrst = 1'b1;
    tick();
    tick();
    check("por_rempty",  {31'd0, ifc.rempty},  32'd1);
    check("por_raempty", {31'd0, ifc.raempty}, 32'd1);
    check("por_rcount",  {27'd0, ifc.rcount},  32'd0);
    check("por_rptr",    {27'd0, ifc.rptr},    32'd0);
    check("por_rvalid",  {31'd0, ifc.rvalid},  32'd0);
    @(negedge rclk);
    rrst = 1'b0;
    #6;

    // Single entry, underflow and almost-empty vectors
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < vecs[i].wr; k++) push(wdata.pop_front());
      ifc.r_en = vecs[i].ren;
      tick();
      check($sformatf("v%0d_rempty", i),  {31'd0, ifc.rempty},  {31'd0, vecs[i].e_empty});
      check($sformatf("v%0d_raempty", i), {31'd0, ifc.raempty}, {31'd0, vecs[i].e_aempty});
      check($sformatf("v%0d_rcount", i),  {27'd0, ifc.rcount},  {27'd0, vecs[i].e_count});
      check($sformatf("v%0d_raddr", i),   {28'd0, ifc.raddr},   {28'd0, vecs[i].e_raddr});
      check($sformatf("v%0d_rptr", i),    {27'd0, ifc.rptr},    {27'd0, vecs[i].e_rptr});
      check($sformatf("v%0d_rvalid", i),  {31'd0, ifc.rvalid},  {31'd0, vecs[i].e_rvalid});
      check($sformatf("v%0d_rdata", i),   {24'd0, ifc.rdata},   {24'd0, vecs[i].e_rdata});
    end
    ifc.r_en = 1'b0;

    // Reset asserted mid-read
    push(8'h66); push(8'h77); push(8'h88);
    tick(); tick(); tick();
    check("pre_rst_rempty", {31'd0, ifc.rempty}, 32'd0);
    ifc.r_en = 1'b1;
    tick();
    #2;
    rrst = 1'b1;
    sb.delete();
    wbin = '0;
    ifc.wptr = '0;
    #1;
    check("rst_rempty",  {31'd0, ifc.rempty},  32'd1);
    check("rst_raempty", {31'd0, ifc.raempty}, 32'd1);
    check("rst_rcount",  {27'd0, ifc.rcount},  32'd0);
    check("rst_rptr",    {27'd0, ifc.rptr},    32'd0);
    check("rst_raddr",   {28'd0, ifc.raddr},   32'd0);
    check("rst_rvalid",  {31'd0, ifc.rvalid},  32'd0);
    check("rst_rdata",   {24'd0, ifc.rdata},   32'd0);
    tick();
    @(negedge rclk);
    rrst = 1'b0;
    tick();
    ifc.r_en = 1'b0;
    check("post_rst_rempty", {31'd0, ifc.rempty}, 32'd1);
    check("post_rst_rptr",   {27'd0, ifc.rptr},   32'd0);
    check("post_rst_raddr",  {28'd0, ifc.raddr},  32'd0);
    check("post_rst_rvalid", {31'd0, ifc.rvalid}, 32'd0);

    // Full 16-entry burst across the wrap point
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    check("wrap_wptr", {27'd0, ifc.wptr}, 32'h18);
    tick(); tick(); tick();
    check("wrap_rcount",  {27'd0, ifc.rcount},  32'd16);
    check("wrap_rempty",  {31'd0, ifc.rempty},  32'd0);
    check("wrap_raempty", {31'd0, ifc.raempty}, 32'd0);
    n_pulse = 0;
    ifc.r_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wrap_raddr%0d", i), {28'd0, ifc.raddr}, i);
      tick();
    end
    ifc.r_en = 1'b0;
    check("wrap_raddr_end", {28'd0, ifc.raddr},  32'd0);
    check("wrap_rptr_end",  {27'd0, ifc.rptr},   32'h18);
    check("wrap_rempty_end",{31'd0, ifc.rempty}, 32'd1);
    check("wrap_rcount_end",{27'd0, ifc.rcount}, 32'd0);
    @(negedge rclk);
    #1;
    check("wrap_pulses", n_pulse, 32'd16);
    check("wrap_sb_left", sb.size(), 32'd0);

    // Write lands while the last entry is being read
    push(8'hC1);
    tick(); tick(); tick();
    check("sim_rempty0", {31'd0, ifc.rempty}, 32'd0);
    check("sim_rcount0", {27'd0, ifc.rcount}, 32'd1);
    push(8'hC2);
    ifc.r_en = 1'b1;
    tick();
    ifc.r_en = 1'b0;
    check("sim_pulse_e1", {31'd0, ifc.rempty}, 32'd1);
    check("sim_rvalid",   {31'd0, ifc.rvalid}, 32'd1);
    tick();
    check("sim_pulse_e2", {31'd0, ifc.rempty}, 32'd1);
    tick();
    check("sim_clear_e3", {31'd0, ifc.rempty}, 32'd0);
    check("sim_rcount3",  {27'd0, ifc.rcount}, 32'd1);
    ifc.r_en = 1'b1;
    tick();
    ifc.r_en = 1'b0;
    check("sim_rempty_end", {31'd0, ifc.rempty}, 32'd1);
    @(negedge rclk);
    #1;
    check("sim_sb_left", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
